// File: rtl/opl2_host_write_ctrl.sv
// OPL2 host write port: synchronizes the async bus, decodes address/data writes, paces them with busy.
// Latency: 3 clk edges from strobe to action; no backpressure, writes during busy are dropped and flag overrun.

module opl2_sync2 #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] s1_q;
  logic [DATA_WIDTH-1:0] s2_q;

  // Intentionally unreset: the previous-strobe register masks power-up contents.
  always_ff @(posedge clk) begin
    s1_q <= d;
    s2_q <= s1_q;
  end

  assign q = s2_q;
endmodule

module opl2_host_write_ctrl #(
  parameter int ADDR_WAIT_CYCLES = 12,
  parameter int DATA_WAIT_CYCLES = 84
) (
  input  logic       clk,
  input  logic       ic_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       clr_overrun,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       overrun
);
  localparam int MAX_WAIT = (ADDR_WAIT_CYCLES > DATA_WAIT_CYCLES) ? ADDR_WAIT_CYCLES : DATA_WAIT_CYCLES;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_WAIT_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ADDR_WAIT = 2'd1;
  localparam logic [1:0] DATA_WAIT = 2'd2;

  logic [10:0] sync_s;
  logic        cs_n_s;
  logic        wr_n_s;
  logic        a0_s;
  logic [7:0]  din_s;
  logic        strobe_s;
  logic        wr_evt;

  logic [1:0]    state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_data_q, reg_data_d;
  logic          reg_wr_q,   reg_wr_d;
  logic          overrun_q,  overrun_d;
  logic          strb_prev_q, strb_prev_d;

  opl2_sync2 #(.DATA_WIDTH(11)) u_sync (
    .clk (clk),
    .d   ({cs_n, wr_n, a0, din}),
    .q   (sync_s)
  );

  assign {cs_n_s, wr_n_s, a0_s, din_s} = sync_s;
  assign strobe_s = !cs_n_s && !wr_n_s;
  assign wr_evt   = strobe_s && !strb_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    reg_wr_d    = 1'b0;
    strb_prev_d = strobe_s;
    overrun_d   = overrun_q && !clr_overrun;
    case (state_q)
      IDLE: begin
        if (wr_evt) begin
          if (a0_s) begin
            reg_data_d = din_s;
            reg_wr_d   = 1'b1;
            state_d    = DATA_WAIT;
            cnt_d      = DATA_LOAD;
          end else begin
            reg_addr_d = din_s;
            state_d    = ADDR_WAIT;
            cnt_d      = ADDR_LOAD;
          end
        end
      end
      ADDR_WAIT, DATA_WAIT: begin
        if (wr_evt) begin
          overrun_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_addr_q  <= 8'h00;
      reg_data_q  <= 8'h00;
      reg_wr_q    <= 1'b0;
      overrun_q   <= 1'b0;
      strb_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      reg_wr_q    <= reg_wr_d;
      overrun_q   <= overrun_d;
      strb_prev_q <= strb_prev_d;
    end
  end

  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign reg_wr   = reg_wr_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_opl2_host_write_ctrl.sv
// Bench for opl2_host_write_ctrl: vector table, timed corner sequences and random traffic vs a busy-countdown model.
// Inputs change 2 time units after posedge; outputs are compared on every negedge.

module tb_opl2_host_write_ctrl;
  localparam int AW = 12;
  localparam int DW = 84;

  logic       clk;
  logic       ic_n;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic       clr_overrun;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic       overrun;

  int total;
  int bad;
  int wr_cnt;
  bit chk_en;

  opl2_host_write_ctrl #(.ADDR_WAIT_CYCLES(AW), .DATA_WAIT_CYCLES(DW)) dut (
    .clk         (clk),
    .ic_n        (ic_n),
    .cs_n        (cs_n),
    .wr_n        (wr_n),
    .a0          (a0),
    .din         (din),
    .clr_overrun (clr_overrun),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .reg_wr      (reg_wr),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: pins seen two edges late, busy tracked as a count of remaining cycles.
  typedef struct packed {
    logic       cs;
    logic       wr;
    logic       a0;
    logic [7:0] din;
  } pin_t;

  pin_t       p1 = '{cs: 1'b1, wr: 1'b1, a0: 1'b0, din: 8'h00};
  pin_t       p2 = '{cs: 1'b1, wr: 1'b1, a0: 1'b0, din: 8'h00};
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  bit         m_wr   = 1'b0;
  bit         m_ovr  = 1'b0;
  bit         m_prev = 1'b1;
  int         m_left = 0;

  always @(posedge clk) begin
    bit act;
    bit evt;
    bit drop;
    act = !p2.cs && !p2.wr;
    if (!ic_n) begin
      m_addr = 8'h00;
      m_data = 8'h00;
      m_wr   = 1'b0;
      m_ovr  = 1'b0;
      m_left = 0;
      m_prev = 1'b1;
    end else begin
      evt    = act && !m_prev;
      m_prev = act;
      m_wr   = 1'b0;
      drop   = 1'b0;
      if (m_left > 0) begin
        drop   = evt;
        m_left = m_left - 1;
      end else if (evt) begin
        if (p2.a0) begin
          m_data = p2.din;
          m_wr   = 1'b1;
          m_left = DW;
        end else begin
          m_addr = p2.din;
          m_left = AW;
        end
      end
      m_ovr = (m_ovr && !clr_overrun) || drop;
    end
    p2 = p1;
    p1 = '{cs: cs_n, wr: wr_n, a0: a0, din: din};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] exp_v;
    if (chk_en) begin
      if (!ic_n) exp_v = '0;
      else       exp_v = {m_addr, m_data, m_wr, (m_left > 0), m_ovr};
      chk("model", {13'd0, reg_addr, reg_data, reg_wr, busy, overrun}, {13'd0, exp_v});
      if (reg_wr === 1'b1) wr_cnt = wr_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe_lo(input logic sel, input logic [7:0] d);
    a0   = sel;
    din  = d;
    cs_n = 1'b0;
    wr_n = 1'b0;
  endtask

  task automatic strobe_hi();
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_write(input logic sel, input logic [7:0] d, input int hold);
    strobe_lo(sel, d);
    tick(hold);
    strobe_hi();
    tick(4);
    wait_idle();
    tick(1);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick(1);
    end
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] din;
    int         hold;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    int         e_wr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int w0;
    int n;
    total = 0;
    bad = 0;
    wr_cnt = 0;
    chk_en = 1'b0;
    ic_n = 1'b0;
    strobe_hi();
    a0 = 1'b0;
    din = 8'h00;
    clr_overrun = 1'b0;

    tbl[0] = '{1'b0, 8'hB0, 2, 8'hB0, 8'h00, 0};
    tbl[1] = '{1'b1, 8'h2A, 1, 8'hB0, 8'h2A, 1};
    tbl[2] = '{1'b1, 8'h55, 5, 8'hB0, 8'h55, 1};
    tbl[3] = '{1'b0, 8'hC3, 1, 8'hC3, 8'h55, 0};
    tbl[4] = '{1'b1, 8'hFF, 3, 8'hC3, 8'hFF, 1};
    tbl[5] = '{1'b0, 8'h00, 2, 8'h00, 8'hFF, 0};
    tbl[6] = '{1'b1, 8'h81, 1, 8'h00, 8'h81, 1};

    tick(5);
    chk("reset_outs", {13'd0, reg_addr, reg_data, reg_wr, busy, overrun}, 32'd0);
    ic_n = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(2);
    chk("post_reset", {13'd0, reg_addr, reg_data, reg_wr, busy, overrun}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt;
      do_write(tbl[i].a0, tbl[i].din, tbl[i].hold);
      chk($sformatf("vec%0d_addr", i), {24'd0, reg_addr}, {24'd0, tbl[i].e_addr});
      chk($sformatf("vec%0d_data", i), {24'd0, reg_data}, {24'd0, tbl[i].e_data});
      chk($sformatf("vec%0d_wr", i), wr_cnt - w0, tbl[i].e_wr);
      chk($sformatf("vec%0d_ovr", i), {31'd0, overrun}, 32'd0);
    end

    // Latency and busy lengths.
    strobe_lo(1'b0, 8'hB0);
    tick(2);
    chk("addr_lat2_busy", {31'd0, busy}, 32'd0);
    tick(1);
    strobe_hi();
    chk("addr_lat3_addr", {24'd0, reg_addr}, 32'hB0);
    busy_len(n);
    chk("addr_busy_len", n, AW);
    tick(1);
    strobe_lo(1'b1, 8'h2A);
    tick(1);
    chk("data_lat1_wr", {31'd0, reg_wr}, 32'd0);
    tick(1);
    chk("data_lat2_wr", {31'd0, reg_wr}, 32'd0);
    tick(1);
    strobe_hi();
    chk("data_lat3_wr", {31'd0, reg_wr}, 32'd1);
    chk("data_lat3_dat", {24'd0, reg_data}, 32'h2A);
    busy_len(n);
    chk("data_busy_len", n, DW);

    // Data write lands in ADDR_WAIT cycle 5: dropped.
    tick(1);
    w0 = wr_cnt;
    strobe_lo(1'b0, 8'h44);
    tick(3);
    strobe_hi();
    tick(2);
    strobe_lo(1'b1, 8'h99);
    tick(2);
    strobe_hi();
    tick(2);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_idle();
    chk("ovr_no_wr", wr_cnt - w0, 0);
    chk("ovr_data_kept", {24'd0, reg_data}, 32'h2A);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Event in last busy cycle (dropped) vs first idle cycle (accepted).
    w0 = wr_cnt;
    strobe_lo(1'b1, 8'h11);
    tick(3);
    strobe_hi();
    tick(81);
    strobe_lo(1'b1, 8'h22);
    tick(2);
    strobe_hi();
    wait_idle();
    tick(2);
    chk("last_busy_drop_ovr", {31'd0, overrun}, 32'd1);
    chk("last_busy_drop_dat", {24'd0, reg_data}, 32'h11);
    chk("last_busy_drop_wr", wr_cnt - w0, 1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    w0 = wr_cnt;
    strobe_lo(1'b1, 8'h22);
    tick(3);
    strobe_hi();
    tick(82);
    strobe_lo(1'b1, 8'h33);
    tick(2);
    strobe_hi();
    tick(2);
    chk("first_idle_acc_dat", {24'd0, reg_data}, 32'h33);
    chk("first_idle_acc_wr", wr_cnt - w0, 2);
    chk("first_idle_acc_ovr", {31'd0, overrun}, 32'd0);
    wait_idle();
    tick(1);

    // Clear coincident with a dropped write: set wins.
    strobe_lo(1'b0, 8'h5A);
    tick(3);
    strobe_hi();
    tick(1);
    strobe_lo(1'b1, 8'h77);
    tick(2);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    strobe_hi();
    chk("set_wins", {31'd0, overrun}, 32'd1);
    wait_idle();
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;

    // Held strobe gives one write; reset release under a held strobe gives none.
    w0 = wr_cnt;
    strobe_lo(1'b1, 8'h9C);
    tick(200);
    strobe_hi();
    wait_idle();
    tick(1);
    chk("held_one_wr", wr_cnt - w0, 1);
    w0 = wr_cnt;
    strobe_lo(1'b1, 8'h9D);
    tick(1);
    ic_n = 1'b0;
    tick(3);
    ic_n = 1'b1;
    tick(20);
    chk("rst_held_no_wr", wr_cnt - w0, 0);
    chk("rst_held_data", {24'd0, reg_data}, 32'h00);
    strobe_hi();
    tick(3);
    strobe_lo(1'b1, 8'h9E);
    tick(3);
    strobe_hi();
    wait_idle();
    tick(1);
    chk("rst_reedge_wr", wr_cnt - w0, 1);
    chk("rst_reedge_dat", {24'd0, reg_data}, 32'h9E);

    // Reset mid DATA_WAIT at cycle 40.
    do_write(1'b0, 8'h12, 1);
    strobe_lo(1'b1, 8'h34);
    tick(3);
    strobe_hi();
    tick(39);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    ic_n = 1'b0;
    #1;
    chk("mid_rst_outs", {13'd0, reg_addr, reg_data, reg_wr, busy, overrun}, 32'd0);
    tick(2);
    ic_n = 1'b1;
    tick(2);
    do_write(1'b0, 8'h66, 2);
    chk("after_rst_addr", {24'd0, reg_addr}, 32'h66);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 250; i++) begin
      int gap;
      a0   = 1'($urandom_range(0, 1));
      din  = 8'($urandom);
      cs_n = ($urandom_range(0, 9) == 0);
      wr_n = 1'b0;
      tick($urandom_range(1, 4));
      strobe_hi();
      gap = $urandom_range(0, 100);
      for (int j = 0; j < gap; j++) begin
        clr_overrun = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 499) == 0) ic_n = 1'b0;
        tick(1);
        ic_n = 1'b1;
      end
      clr_overrun = 1'b0;
    end
    tick(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/opl2_host_write_ctrl.md
OPL2_HOST_WRITE_CTRL -- requirements
Module: opl2_host_write_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WAIT_CYCLES, default 12: busy duration after an address-port write.
REQ-002 SHALL have parameter DATA_WAIT_CYCLES, default 84: busy duration after a data-port write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ic_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cs_n, input, 1 bit: host chip select, asynchronous to clk, active-low.
REQ-006 SHALL have port wr_n, input, 1 bit: host write strobe, asynchronous to clk, active-low.
REQ-007 SHALL have port a0, input, 1 bit: host port select (0 = address port, 1 = data port), asynchronous to clk.
REQ-008 SHALL have port din, input, 8 bits: host write data, asynchronous to clk.
REQ-009 SHALL have port clr_overrun, input, 1 bit: synchronous clear of overrun.
REQ-010 SHALL have port reg_addr, output, 8 bits: latched register address.
REQ-011 SHALL have port reg_data, output, 8 bits: register write data.
REQ-012 SHALL have port reg_wr, output, 1 bit: one-cycle register-file write pulse.
REQ-013 SHALL have port busy, output, 1 bit: high while a post-write wait is in progress.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-015 SHALL pass cs_n, wr_n, a0 and din through the team's 2-stage synchronizer (DATA_WIDTH 11) before any use; no raw host input SHALL reach other logic.
REQ-016 SHALL define the synchronized strobe as (cs_n_s == 0 && wr_n_s == 0), and a write event as its inactive->active transition, detected against a registered copy of the previous value.
REQ-017 SHALL capture a0_s and din_s in the cycle the write event is detected; the host holds a0/din stable while the strobe is active.
REQ-018 Latency: the action SHALL take effect on the 3rd rising clk edge after the first edge that samples the strobe active at the pins (2 edges synchronizer, 1 edge edge-detect/FSM register).
REQ-019 SHALL implement an FSM with states IDLE, ADDR_WAIT and DATA_WAIT.
REQ-020 IDLE, write event, a0=0: reg_addr <= din; go to ADDR_WAIT; busy=1 for exactly ADDR_WAIT_CYCLES cycles; reg_wr stays 0.
REQ-021 IDLE, write event, a0=1: reg_data <= din; reg_wr=1 for exactly one cycle with the current reg_addr; go to DATA_WAIT; busy=1 for exactly DATA_WAIT_CYCLES cycles, starting in the reg_wr cycle.
REQ-022 Wait counter: width clog2(max(ADDR_WAIT_CYCLES, DATA_WAIT_CYCLES)+1); loads N-1 on entry and decrements; at 0 the FSM returns to IDLE on the next edge, which lowers busy.
REQ-023 A write event arriving in the final busy cycle, or any earlier busy cycle, SHALL be dropped with no change to reg_addr, reg_data or reg_wr, and SHALL set overrun.
REQ-024 A write event in the first IDLE cycle after busy falls SHALL be accepted normally.
REQ-025 overrun SHALL be cleared by clr_overrun; if set and clear occur in the same cycle, set wins.
REQ-026 A strobe held active continuously SHALL produce exactly one write event.
REQ-027 reg_addr SHALL persist across data writes, so repeated data writes target the same register.

Reset
REQ-028 ic_n low SHALL asynchronously force IDLE, counter=0, reg_addr=0x00, reg_data=0x00, reg_wr=0, busy=0 and overrun=0.
REQ-029 The previous-strobe register SHALL reset to "active", so a strobe that is active during or after reset release generates no write; only an inactive->active transition after release is a write.
REQ-030 ic_n asserted mid-wait SHALL abort the wait immediately; no reg_wr SHALL occur during or at release of reset.
REQ-031 The synchronizer stages are not reset; REQ-029 masks their power-up contents.

Verification
REQ-032 Address write a0=0, din=0xB0, then data write a0=1, din=0x2A after busy falls -> reg_addr=0xB0; one reg_wr pulse with reg_data=0x2A 3 edges after the strobe; busy high 12 cycles, then 84 cycles.
REQ-033 Data write during ADDR_WAIT (cycle 5 of 12) -> no reg_wr, reg_data unchanged, overrun=1; a later clr_overrun pulse -> overrun=0.
REQ-034 Write event exactly in the first IDLE cycle after DATA_WAIT -> accepted; write event in the last busy cycle -> dropped, overrun=1.
REQ-035 Strobe held low for 200 cycles -> exactly one reg_wr; ic_n released while the strobe is held low -> zero writes until the strobe goes high and then low again.
REQ-036 ic_n pulsed low at cycle 40 of DATA_WAIT -> busy=0, outputs 0x00 the same cycle; after release, a new address write is accepted normally.
REQ-037 clr_overrun asserted in the same cycle as a dropped write -> overrun remains 1.
